gb_timer_unit: RTL and testbench

//  Parametrised successor to the DIV/TIMA timer block. Provides a CPU-writable DIV/TIMA/TMA/TAC

---
 rtl/gb_timer_unit.sv | 136 +++++++++++++
 tb/tb_gb_timer_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_timer_unit.sv
// DIV/TIMA/TMA/TAC timer block: shared system counter, falling-edge tap detection,
// delayed TIMA overflow with a cancellable TMA reload and INT 0x50 pulse.
module gb_timer_unit #(
  parameter int unsigned SYS_W   = 14,
  parameter int unsigned TAP0    = 7,
  parameter int unsigned TAP1    = 1,
  parameter int unsigned TAP2    = 3,
  parameter int unsigned TAP3    = 5,
  parameter int unsigned RLD_DLY = 1
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iTick,
  input  logic       iWe,
  input  logic [1:0] iAddr,
  input  logic [7:0] iWData,
  output logic [7:0] oRData,
  output logic [7:0] oDiv,
  output logic [7:0] oTima,
  output logic [7:0] oTma,
  output logic [7:0] oTac,
  output logic       oInterrupt0x50
);

  typedef enum logic [1:0] {COUNT, OVF, RELOAD} state_t;

  logic [SYS_W-1:0] rSys;
  logic [7:0]       rTima;
  logic [7:0]       rTma;
  logic [2:0]       rTac;
  logic             rTapQ;
  logic [1:0]       rCnt;
  logic             rIrq;
  state_t           rState;

  logic wSel;
  logic wTap;
  logic wFall;
  logic wWrDiv;
  logic wWrTima;
  logic wWrTma;
  logic wWrTac;

  always_comb begin
    wSel = 1'b0;
    case (rTac[1:0])
      2'd0:    wSel = rSys[TAP0];
      2'd1:    wSel = rSys[TAP1];
      2'd2:    wSel = rSys[TAP2];
      default: wSel = rSys[TAP3];
    endcase
  end

  assign wTap    = wSel & rTac[2];
  assign wFall   = rTapQ & ~wTap;
  assign wWrDiv  = iWe && (iAddr == 2'd0);
  assign wWrTima = iWe && (iAddr == 2'd1);
  assign wWrTma  = iWe && (iAddr == 2'd2);
  assign wWrTac  = iWe && (iAddr == 2'd3);

  // Counter, register file and overflow/reload sequencing
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rSys   <= '0;
      rTima  <= 8'h00;
      rTma   <= 8'h00;
      rTac   <= 3'b000;
      rTapQ  <= 1'b0;
      rCnt   <= 2'd0;
      rIrq   <= 1'b0;
      rState <= COUNT;
    end else begin
      rTapQ <= wTap;
      rIrq  <= 1'b0;

      if (wWrDiv)     rSys <= '0;
      else if (iTick) rSys <= rSys + SYS_W'(1);

      if (wWrTma) rTma <= iWData;
      if (wWrTac) rTac <= iWData[2:0];

      case (rState)
        COUNT: begin
          if (wWrTima) begin
            rTima <= iWData;
          end else if (wFall) begin
            if (rTima == 8'hFF) begin
              rTima  <= 8'h00;
              rCnt   <= 2'(RLD_DLY);
              rState <= OVF;
            end else begin
              rTima <= rTima + 8'd1;
            end
          end
        end
        OVF: begin
          // A CPU write here aborts the pending reload and its interrupt
          if (wWrTima) begin
            rTima  <= iWData;
            rState <= COUNT;
          end else if (iTick) begin
            if (rCnt <= 2'd1) begin
              rCnt   <= 2'd0;
              rIrq   <= 1'b1;
              rState <= RELOAD;
            end else begin
              rCnt <= rCnt - 2'd1;
            end
          end
        end
        RELOAD: begin
          rTima  <= wWrTma ? iWData : rTma;
          rState <= COUNT;
        end
        default: rState <= COUNT;
      endcase
    end
  end

  assign oDiv           = rSys[SYS_W-1 -: 8];
  assign oTima          = rTima;
  assign oTma           = rTma;
  assign oTac           = {5'b11111, rTac};
  assign oInterrupt0x50 = rIrq;

  always_comb begin
    oRData = 8'h00;
    case (iAddr)
      2'd0:    oRData = oDiv;
      2'd1:    oRData = rTima;
      2'd2:    oRData = rTma;
      default: oRData = oTac;
    endcase
  end

endmodule

// File: tb/tb_gb_timer_unit.sv
// Self-checking bench for gb_timer_unit: register table, directed overflow/reload
// scenarios and a long randomized run against a cycle-level reference model.
module tb_gb_timer_unit;

  localparam int RLD = 1;

  logic       iClock = 1'b0;
  logic       iReset = 1'b0;
  logic       iTick  = 1'b0;
  logic       iWe    = 1'b0;
  logic [1:0] iAddr  = 2'd0;
  logic [7:0] iWData = 8'h00;
  logic [7:0] oRData, oDiv, oTima, oTma, oTac;
  logic       oInterrupt0x50;

  gb_timer_unit dut (
    .iClock(iClock), .iReset(iReset), .iTick(iTick), .iWe(iWe), .iAddr(iAddr),
    .iWData(iWData), .oRData(oRData), .oDiv(oDiv), .oTima(oTima), .oTma(oTma),
    .oTac(oTac), .oInterrupt0x50(oInterrupt0x50)
  );

  always #5 iClock = ~iClock;

  int nCmp = 0;
  int nErr = 0;

  // Reference model state: plain integers, overflow tracked as ticks remaining
  int  mSys, mTima, mTma, mTac, mOvfLeft;
  bit  mPrevTap, mReloadNow, mIrq;

  function automatic int tapIndex(input int sel);
    case (sel)
      0: return 7;
      1: return 1;
      2: return 3;
      default: return 5;
    endcase
  endfunction

  function automatic int modelRead(input int a);
    case (a)
      0: return (mSys / 64) % 256;
      1: return mTima;
      2: return mTma;
      default: return 248 + mTac;
    endcase
  endfunction

  task automatic modelStep(input bit rst, input bit tick, input bit we, input int a, input int d);
    bit tapNow, fall;
    if (rst) begin
      mSys = 0; mTima = 0; mTma = 0; mTac = 0; mOvfLeft = 0;
      mPrevTap = 0; mReloadNow = 0; mIrq = 0;
      return;
    end
    tapNow = (((mSys >> tapIndex(mTac % 4)) % 2) == 1) && (mTac >= 4);
    fall   = mPrevTap && !tapNow;
    mIrq   = 0;
    if (mReloadNow) begin
      mTima = (we && a == 2) ? d : mTma;
      mReloadNow = 0;
    end else if (mOvfLeft > 0) begin
      if (we && a == 1) begin
        mTima = d; mOvfLeft = 0;
      end else if (tick) begin
        mOvfLeft--;
        if (mOvfLeft == 0) begin mReloadNow = 1; mIrq = 1; end
      end
    end else if (we && a == 1) begin
      mTima = d;
    end else if (fall) begin
      if (mTima == 255) begin mTima = 0; mOvfLeft = RLD; end
      else mTima++;
    end
    mPrevTap = tapNow;
    if (we && a == 0) mSys = 0;
    else if (tick) mSys = (mSys + 1) % 16384;
    if (we && a == 2) mTma = d;
    if (we && a == 3) mTac = d % 8;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, advance model, compare every output against it
  task automatic cyc(input bit rst, input bit tick, input bit we, input int a, input int d);
    iReset = rst; iTick = tick; iWe = we; iAddr = 2'(a); iWData = 8'(d);
    @(posedge iClock);
    modelStep(rst, tick, we, a, d);
    #1;
    chk("div",   int'(oDiv),  (mSys / 64) % 256);
    chk("tima",  int'(oTima), mTima);
    chk("tma",   int'(oTma),  mTma);
    chk("tac",   int'(oTac),  248 + mTac);
    chk("irq",   int'(oInterrupt0x50), int'(mIrq));
    chk("rdata", int'(oRData), modelRead(a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 0, 0, 0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(0, 0, 1, a, d);
  endtask

  // Reset, TAC=07, TMA=0xAB, TIMA=0xFE, then run until TIMA has just wrapped to 0x00
  task automatic toOverflow();
    cyc(1, 0, 0, 0, 0);
    wr(3, 8'h07); wr(2, 8'hAB); wr(1, 8'hFE);
    ticks(128);
    chk("pre_ovf_tima", int'(oTima), 8'hFF);
    ticks(1);
    chk("ovf_tima_zero", int'(oTima), 0);
    chk("ovf_no_irq", int'(oInterrupt0x50), 0);
  endtask

  typedef struct {
    int addr;
    int wdata;
    int expRd;
  } vec_t;

  vec_t tbl[8];
  int   pulses;

  initial begin
    tbl[0] = '{3, 8'hFF, 8'hFF};
    tbl[1] = '{3, 8'h00, 8'hF8};
    tbl[2] = '{3, 8'hFA, 8'hFA};
    tbl[3] = '{3, 8'h00, 8'hF8};
    tbl[4] = '{2, 8'h5C, 8'h5C};
    tbl[5] = '{1, 8'h12, 8'h12};
    tbl[6] = '{0, 8'h77, 8'h00};
    tbl[7] = '{2, 8'hFF, 8'hFF};

    cyc(1, 0, 0, 0, 0);
    chk("rst_tac", int'(oTac), 8'hF8);
    chk("rst_tima", int'(oTima), 0);
    chk("rst_div", int'(oDiv), 0);

    // Register write/readback table (counter held at 0 so no tap edges)
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].addr, tbl[i].wdata);
      chk("tbl_rd", int'(oRData), tbl[i].expRd);
    end

    // 1: TAP1 counting and DIV rollover
    cyc(1, 0, 0, 0, 0);
    wr(3, 8'h05); wr(2, 8'h00);
    ticks(16); idle(1);
    chk("t1_tima", int'(oTima), 4);
    ticks(47);
    chk("t1_div63", int'(oDiv), 0);
    ticks(1);
    chk("t1_div64", int'(oDiv), 1);

    // 2: overflow, one tick at 0x00, reload with single pulse
    toOverflow();
    ticks(1);
    chk("t2_irq", int'(oInterrupt0x50), 1);
    chk("t2_tima_hold", int'(oTima), 0);
    idle(1);
    chk("t2_reload", int'(oTima), 8'hAB);
    chk("t2_irq_end", int'(oInterrupt0x50), 0);

    // 3: TIMA write during OVF cancels reload and interrupt
    toOverflow();
    cyc(0, 1, 1, 1, 8'h33);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, i % 2, 0, 1, 0);
      pulses += int'(oInterrupt0x50);
    end
    chk("t3_tima", int'(oTima), 8'h33);
    chk("t3_no_irq", pulses, 0);

    // 4: DIV clear and TAC change both produce falling edges
    cyc(1, 0, 0, 0, 0);
    wr(3, 8'h05);
    ticks(2); idle(1);
    cyc(0, 1, 1, 0, 0);
    idle(1);
    chk("t4_div_edge", int'(oTima), 1);
    chk("t4_div_zero", int'(oDiv), 0);
    ticks(2); idle(1);
    wr(3, 8'h01);
    idle(1);
    chk("t4_tac_edge", int'(oTima), 2);

    // 5: TMA write in the reload clock feeds TIMA directly
    toOverflow();
    ticks(1);
    pulses = int'(oInterrupt0x50);
    wr(2, 8'h5A);
    pulses += int'(oInterrupt0x50);
    idle(2);
    pulses += int'(oInterrupt0x50);
    chk("t5_tima", int'(oTima), 8'h5A);
    chk("t5_pulses", pulses, 1);

    // 6: reset during OVF
    toOverflow();
    cyc(1, 1, 0, 0, 0);
    chk("t6_tima", int'(oTima), 0);
    chk("t6_tac", int'(oTac), 8'hF8);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, 0);
      pulses += int'(oInterrupt0x50);
    end
    chk("t6_no_irq", pulses, 0);

    // Randomized run against the reference model
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      int a, d, r;
      bit t, w;
      r = int'($urandom_range(0, 99));
      t = ($urandom_range(0, 3) != 0);
      w = ($urandom_range(0, 9) == 0);
      a = int'($urandom_range(0, 3));
      d = int'($urandom_range(0, 255));
      if (w && a == 1 && r < 70) d = 240 + (d % 16);
      if (w && a == 2 && r < 50) d = 240 + (d % 16);
      if (w && a == 3 && r < 80) d = 4 + (d % 4);
      if (w && a == 0 && r < 60) w = 0;
      cyc(r == 99 && i % 7 == 0, t, w, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
